rggen_irq_router: RTL
=====================

Name: rggen_irq_router

Overview:
Multi-output interrupt controller for rggen register blocks. Each source is individually configurable as level- or rising-edge-sensitive, with an optional synchroniser. Edge events are held in sticky pending bits that software clears by writing 1. Every source is routed through its own enable vector to one of IRQ_OUTPUTS registered interrupt lines, and each line carries the priority ID of its winning source.

Parameters:
- TOTAL_INTERRUPTS, 1: number of interrupt sources N (1..1024).
- IRQ_OUTPUTS, 1: number of output interrupt lines M (1..32).
- EDGE_MASK, '0 (N bits): bit n = 1 makes source n rising-edge sensitive; 0 makes it level sensitive.
- SYNC_STAGES, 2: synchroniser flops per source (0..3); 0 bypasses synchronisation.
- ID_WIDTH (localparam): $clog2(N) when N > 1, otherwise 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- i_source  input  N  raw interrupt request inputs.
- i_ier  input  M*N  enable vectors; slice [m*N +: N] gates sources onto output m.
- i_clear  input  N  single-cycle write-1-to-clear strobe for edge pending bits.
- o_isr  output  N  registered pending/status vector for register readback.
- o_irq  output  M  registered interrupt lines.
- o_irq_id  output  M*ID_WIDTH  registered ID of the highest-priority active source per line.

Behaviour:
- Reset: all synchroniser flops, previous-value flops, the isr register, o_irq and o_irq_id go to 0. The values are applied asynchronously on rst_n low and held until the first clk edge after release.
- Synchroniser: chain of SYNC_STAGES flops per source, producing sync[n]. When SYNC_STAGES = 0, sync = i_source with no flops.
- Level source: isr[n] <= sync[n] every cycle. i_clear[n] is ignored.
- Edge source:
  - prev[n] <= sync[n] every cycle; rise = sync & ~prev.
  - isr[n] <= rise | (isr[n] & ~i_clear[n]).
  - Set has priority over clear in the same cycle, so a new event is never lost.
  - Repeated rises while isr[n] = 1 are merged; there is no event counting.
  - A source that is high at reset release counts as a rising edge, because prev resets to 0.
- o_isr = isr register. It is independent of i_ier; masking never discards pending state.
- Per output m:
  - o_irq[m] <= |(isr & i_ier[m*N +: N]).
  - o_irq_id[m] <= index of the lowest-numbered set bit of that masked vector. Index 0 has the highest priority.
  - o_irq_id[m] = 0 when o_irq[m] = 0.
- Latency from an i_source transition to o_irq:
  - SYNC_STAGES + 2 rising edges for both modes.
  - With SYNC_STAGES = 2, a source rising before edge k gives o_irq high after edge k+3.
- Latency from i_clear or an i_ier change to o_irq: 1 cycle for i_ier, 2 cycles for i_clear (isr updates, then o_irq).
- A level source deasserting drops o_irq SYNC_STAGES + 2 cycles later, provided no other enabled source is active.
- One source may be enabled on several outputs simultaneously. Outputs are evaluated independently.
- i_clear on a level source, or on an edge source whose isr is 0, has no effect.
- Reset mid-operation: all pending edge events are discarded, o_irq drops immediately (asynchronously), and there is no recovery of lost events.

Decomposition:
- Package rggen_irq_pkg holds:
  - Function calc_id_width(N).
  - Function rggen_irq_priority_encode, a parametrised lowest-set-bit index with a found flag, implemented as a loop that the tool reduces.
- Sub-module rggen_irq_source, one instance per source via generate. It contains the synchroniser chain, the previous-value flop, the edge/level select (parameter EDGE) and the pending flop, with outputs isr.
- The top level holds the M output reducers and priority encoders, plus the o_irq/o_irq_id registers.

Test Plan:
1. Reset and idle: rst_n low with all inputs = 1 and N=4, M=2 → o_isr, o_irq and o_irq_id are 0 during reset. After release, with EDGE_MASK=4'b0011 and SYNC_STAGES=2, o_isr becomes 4'b1111 after 3 edges and o_irq=2'b11 one edge later when i_ier is all ones.
2. Edge latch and clear: pulse source 1 for 1 cycle with i_ier[0]=4'b0010 → o_irq[0] rises 4 cycles later and stays high after the pulse ends. Assert i_clear=4'b0010 → o_isr[1]=0 after 1 edge and o_irq[0]=0 after 2 edges.
3. Set/clear collision: rising edge on source 0 arrives in the same cycle as i_clear[0]=1 while isr[0] is already 1 → isr[0] remains 1 and o_irq stays asserted.
4. Level follow: hold source 2 (level) high for 10 cycles with SYNC_STAGES=0 → o_irq high 2 cycles after the rise and low 2 cycles after the fall. i_clear[2] pulses during the high period have no effect.
5. Routing and priority: sources 1 and 3 pending, i_ier[0]=4'b1010, i_ier[1]=4'b1000 → o_irq=2'b11, o_irq_id[0]=1, o_irq_id[1]=3. Clearing source 1 gives o_irq_id[0]=3.
6. Masking: with source 0 pending, set i_ier to 0 → o_irq=0 next cycle while o_isr[0] stays 1. Restore i_ier → o_irq=1 next cycle.

Source files
------------

// File: rtl/rggen_irq_pkg.sv
// Shared types and helpers for the rggen interrupt router.
// The priority encoder works on a vector padded to the largest supported source count.
package rggen_irq_pkg;

  localparam int MAX_SOURCES  = 1024;
  localparam int MAX_ID_WIDTH = 10;

  typedef struct packed {
    logic                    found;
    logic [MAX_ID_WIDTH-1:0] id;
  } irq_enc_t;

  function automatic int calc_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scans from the top down so that the lowest set index is the last one written.
  function automatic irq_enc_t rggen_irq_priority_encode(input logic [MAX_SOURCES-1:0] vec);
    irq_enc_t enc;
    enc = '0;
    for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        enc.found = 1'b1;
        enc.id    = MAX_ID_WIDTH'(i);
      end
    end
    return enc;
  endfunction

endpackage

// File: rtl/rggen_irq_source.sv
// One interrupt source: optional synchroniser, then either a level follower
// or a sticky rising-edge pending bit with write-1-to-clear.
module rggen_irq_source #(
  parameter bit EDGE        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_source,
  input  logic i_clear,
  output logic o_isr
);

  logic sync;
  logic prev_q, prev_d;
  logic isr_q, isr_d;
  logic rise;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign sync = i_source;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
      sync_d = SYNC_STAGES'({sync_q, i_source});
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign sync = sync_q[SYNC_STAGES-1];
  end

  // A new rise wins over a simultaneous clear so no event is dropped.
  always_comb begin
    prev_d = sync;
    rise   = sync & ~prev_q;
    isr_d  = EDGE ? (rise | (isr_q & ~i_clear)) : sync;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      isr_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      isr_q  <= isr_d;
    end
  end

  assign o_isr = isr_q;

endmodule

// File: rtl/rggen_irq_router.sv
// Multi-output interrupt router: per-source pending logic, per-output enable
// masking, and a registered line plus lowest-index winner ID per output.
module rggen_irq_router
  import rggen_irq_pkg::*;
#(
  parameter int                          TOTAL_INTERRUPTS = 1,
  parameter int                          IRQ_OUTPUTS      = 1,
  parameter logic [TOTAL_INTERRUPTS-1:0] EDGE_MASK        = '0,
  parameter int                          SYNC_STAGES      = 2,
  localparam int                         ID_WIDTH         = calc_id_width(TOTAL_INTERRUPTS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [TOTAL_INTERRUPTS-1:0]            i_source,
  input  logic [IRQ_OUTPUTS*TOTAL_INTERRUPTS-1:0] i_ier,
  input  logic [TOTAL_INTERRUPTS-1:0]            i_clear,
  output logic [TOTAL_INTERRUPTS-1:0]            o_isr,
  output logic [IRQ_OUTPUTS-1:0]                 o_irq,
  output logic [IRQ_OUTPUTS*ID_WIDTH-1:0]        o_irq_id
);

  localparam int N = TOTAL_INTERRUPTS;
  localparam int M = IRQ_OUTPUTS;

  logic [N-1:0]          isr;
  logic [M-1:0]          irq_q, irq_d;
  logic [M*ID_WIDTH-1:0] irq_id_q, irq_id_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_src
    rggen_irq_source #(
      .EDGE        (EDGE_MASK[gi]),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_source (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_source (i_source[gi]),
      .i_clear  (i_clear[gi]),
      .o_isr    (isr[gi])
    );
  end

  // Masking only gates the outputs; pending state in isr is never touched.
  for (genvar gi = 0; gi < M; gi++) begin : g_out
    logic [N-1:0] masked;
    irq_enc_t     enc;

    assign masked = isr & i_ier[gi*N +: N];
    assign enc    = rggen_irq_priority_encode(MAX_SOURCES'(masked));

    assign irq_d[gi]                          = enc.found;
    assign irq_id_d[gi*ID_WIDTH +: ID_WIDTH]  = enc.found ? ID_WIDTH'(enc.id) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= '0;
      irq_id_q <= '0;
    end else begin
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign o_isr    = isr;
  assign o_irq    = irq_q;
  assign o_irq_id = irq_id_q;

endmodule
